fsk_demod_ctrl: RTL and testbench

Symbol-timing controller in front of the FSK correlator/demodulator. It hunts for the square-wave sync preamble on the I channel and frames the post-sync sample stream into N-sample correlation windows. It starts the correlator on each window and qualifies its decision against an energy threshold. It then emits decoded 4-bit symbols and manages lock, loss of lock and frame length.

---
 rtl/fsk_pkg.sv | 22 ++
 rtl/fsk_sync_detector.sv | 40 ++++
 rtl/fsk_demod_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fsk_demod_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared types and widths for the FSK symbol-timing controller and the correlator it drives.
package fsk_pkg;
  localparam int SYMBOL_W = 4;
  localparam int SAMPLE_W = 17;
  localparam int ENERGY_W = 32;

  localparam int          DEFAULT_N                = 99;
  localparam int unsigned DEFAULT_ENERGY_THRESHOLD = 10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_GUARD,
    ST_COLLECT,
    ST_EVAL
  } state_e;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/fsk_sync_detector.sv
// Preamble hunter: counts consecutive valid I samples above threshold and pulses sync_hit
// on the sample that completes the run.
module fsk_sync_detector
  import fsk_pkg::*;
#(
  parameter int SYNC_THRESHOLD = 1,
  parameter int SYNC_COUNT     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  output logic                       sync_hit
);
  localparam int                          RUN_W  = cnt_w(SYNC_COUNT);
  localparam logic signed [SAMPLE_W-1:0]  THRESH = SAMPLE_W'(SYNC_THRESHOLD);

  logic [RUN_W-1:0] run_q, run_d;
  logic             is_high;

  assign is_high  = sample_valid && (sample_i > THRESH);
  assign sync_hit = !clear && is_high && (run_q == RUN_W'(SYNC_COUNT - 1));

  always_comb begin
    // NOTE: default first so every path assigns run_d and no latch is inferred.
    run_d = run_q;
    if (clear || sync_hit) begin
      run_d = '0;
    end else if (sample_valid) begin
      run_d = is_high ? run_q + RUN_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (reset) run_q <= '0;
    else       run_q <= run_d;
  end
endmodule

// File: rtl/fsk_demod_ctrl.sv
// Symbol-timing controller: hunts the sync preamble, frames N-sample correlation windows,
// qualifies correlator decisions by energy and manages lock, misses and frame length.
module fsk_demod_ctrl
  import fsk_pkg::*;
#(
  parameter int          N                = DEFAULT_N,
  parameter int          SYNC_THRESHOLD   = 1,
  parameter int          SYNC_COUNT       = 8,
  parameter int          GUARD_LEN        = 0,
  parameter int          FRAME_SYMBOLS    = 16,
  parameter int unsigned ENERGY_THRESHOLD = DEFAULT_ENERGY_THRESHOLD,
  parameter int          MAX_MISSES       = 2,
  parameter int          CORR_TIMEOUT     = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic signed [SAMPLE_W-1:0] sample_q,
  output logic                       win_valid,
  output logic signed [SAMPLE_W-1:0] win_i,
  output logic signed [SAMPLE_W-1:0] win_q,
  output logic                       win_last,
  output logic                       corr_start,
  input  logic                       corr_done,
  input  logic [SYMBOL_W-1:0]        corr_symbol,
  input  logic [ENERGY_W-1:0]        corr_energy,
  output logic [SYMBOL_W-1:0]        data_out,
  output logic                       data_valid,
  output logic                       sync_locked,
  output logic                       frame_done,
  output logic                       overrun,
  output logic                       timeout
);
  localparam int SCNT_W = cnt_w(N - 1);
  localparam int GCNT_W = cnt_w(GUARD_LEN);
  localparam int WAIT_W = cnt_w(CORR_TIMEOUT);
  localparam int SYM_W  = cnt_w(FRAME_SYMBOLS);
  localparam int MISS_W = cnt_w(MAX_MISSES);

  // All controller state in one record so reset and the default hold stay in one place.
  typedef struct packed {
    state_e                     state;
    logic [SCNT_W-1:0]          sample_cnt;
    logic [GCNT_W-1:0]          guard_cnt;
    logic [WAIT_W-1:0]          wait_cnt;
    logic [SYM_W-1:0]           sym_cnt;
    logic [MISS_W-1:0]          miss_cnt;
    logic                       win_valid;
    logic signed [SAMPLE_W-1:0] win_i;
    logic signed [SAMPLE_W-1:0] win_q;
    logic                       win_last;
    logic                       corr_start;
    logic [SYMBOL_W-1:0]        data_out;
    logic                       data_valid;
    logic                       frame_done;
    logic                       overrun;
    logic                       timeout;
  } ctrl_t;

  ctrl_t r_q, r_d;
  logic  sync_hit;
  logic  energy_ok;

  fsk_sync_detector #(
    .SYNC_THRESHOLD (SYNC_THRESHOLD),
    .SYNC_COUNT     (SYNC_COUNT)
  ) u_sync (
    .clk          (clk),
    .reset        (reset),
    .clear        ((r_q.state != ST_HUNT) || !enable),
    .sample_valid (sample_valid),
    .sample_i     (sample_i),
    .sync_hit     (sync_hit)
  );

  assign energy_ok = corr_energy > ENERGY_W'(ENERGY_THRESHOLD);

  always_comb begin
    r_d            = r_q;
    r_d.win_valid  = 1'b0;
    r_d.win_last   = 1'b0;
    r_d.corr_start = 1'b0;
    r_d.data_valid = 1'b0;
    r_d.frame_done = 1'b0;
    if (!enable) begin
      r_d.state = ST_IDLE;
    end else begin
      case (r_q.state)
        ST_IDLE: begin
          r_d.state   = ST_HUNT;
          r_d.overrun = 1'b0;
          r_d.timeout = 1'b0;
        end
        ST_HUNT: begin
          r_d.sym_cnt    = '0;
          r_d.miss_cnt   = '0;
          r_d.sample_cnt = '0;
          r_d.guard_cnt  = '0;
          if (sync_hit) r_d.state = (GUARD_LEN == 0) ? ST_COLLECT : ST_GUARD;
        end
        ST_GUARD: begin
          if (sample_valid) begin
            if (r_q.guard_cnt == GCNT_W'(GUARD_LEN - 1)) begin
              r_d.guard_cnt = '0;
              r_d.state     = ST_COLLECT;
            end else begin
              r_d.guard_cnt = r_q.guard_cnt + GCNT_W'(1);
            end
          end
        end
        ST_COLLECT: begin
          if (sample_valid) begin
            r_d.win_valid = 1'b1;
            r_d.win_i     = sample_i;
            r_d.win_q     = sample_q;
            if (r_q.sample_cnt == SCNT_W'(N - 1)) begin
              r_d.win_last   = 1'b1;
              r_d.corr_start = 1'b1;
              r_d.sample_cnt = '0;
              r_d.wait_cnt   = '0;
              r_d.state      = ST_EVAL;
            end else begin
              r_d.sample_cnt = r_q.sample_cnt + SCNT_W'(1);
            end
          end
        end
        ST_EVAL: begin
          if (sample_valid) r_d.overrun = 1'b1;
          // A result on the expiry cycle still counts: corr_done is tested before the timer.
          if (corr_done) begin
            if (energy_ok) begin
              r_d.data_out   = corr_symbol;
              r_d.data_valid = 1'b1;
              r_d.miss_cnt   = '0;
              if (r_q.sym_cnt == SYM_W'(FRAME_SYMBOLS - 1)) begin
                r_d.frame_done = 1'b1;
                r_d.sym_cnt    = '0;
                r_d.state      = ST_HUNT;
              end else begin
                r_d.sym_cnt = r_q.sym_cnt + SYM_W'(1);
                r_d.state   = ST_COLLECT;
              end
            end else if (r_q.miss_cnt == MISS_W'(MAX_MISSES - 1)) begin
              r_d.state = ST_HUNT;
            end else begin
              r_d.miss_cnt = r_q.miss_cnt + MISS_W'(1);
              r_d.state    = ST_COLLECT;
            end
          end else if (r_q.wait_cnt == WAIT_W'(CORR_TIMEOUT - 1)) begin
            r_d.timeout = 1'b1;
            r_d.state   = ST_HUNT;
          end else begin
            r_d.wait_cnt = r_q.wait_cnt + WAIT_W'(1);
          end
        end
        default: r_d.state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_q <= '0;
    else       r_q <= r_d;
  end

  assign win_valid   = r_q.win_valid;
  assign win_i       = r_q.win_i;
  assign win_q       = r_q.win_q;
  assign win_last    = r_q.win_last;
  assign corr_start  = r_q.corr_start;
  assign data_out    = r_q.data_out;
  assign data_valid  = r_q.data_valid;
  assign frame_done  = r_q.frame_done;
  assign overrun     = r_q.overrun;
  assign timeout     = r_q.timeout;
  assign sync_locked = (r_q.state == ST_GUARD) || (r_q.state == ST_COLLECT) ||
                       (r_q.state == ST_EVAL);
endmodule

// File: tb/tb_fsk_demod_ctrl.sv
// Directed sequence with randomized sample data, symbols, energies and result latency,
// checked against a symbol/miss/frame model of the controller's rules.
module tb_fsk_demod_ctrl;
  import fsk_pkg::*;

  localparam int          N             = 99;
  localparam int          SYNC_COUNT    = 8;
  localparam int          GUARD_LEN     = 2;
  localparam int          FRAME_SYMBOLS = 3;
  localparam int          MAX_MISSES    = 2;
  localparam int          CORR_TIMEOUT  = 10;
  localparam int unsigned E_TH          = 10000;

  logic               clk = 1'b0;
  logic               reset, enable, sample_valid, corr_done;
  logic signed [16:0] sample_i, sample_q;
  logic [3:0]         corr_symbol;
  logic [31:0]        corr_energy;
  logic               win_valid, win_last, corr_start, data_valid;
  logic               sync_locked, frame_done, overrun, timeout;
  logic signed [16:0] win_i, win_q;
  logic [3:0]         data_out;

  int         n_asserts = 0;
  int         n_fail    = 0;
  int         m_syms    = 0;
  int         m_misses  = 0;
  logic [3:0] m_data    = 4'd0;
  logic       m_overrun = 1'b0;

  always #5 clk = ~clk;

  fsk_demod_ctrl #(
    .N                (N),
    .SYNC_THRESHOLD   (1),
    .SYNC_COUNT       (SYNC_COUNT),
    .GUARD_LEN        (GUARD_LEN),
    .FRAME_SYMBOLS    (FRAME_SYMBOLS),
    .ENERGY_THRESHOLD (E_TH),
    .MAX_MISSES       (MAX_MISSES),
    .CORR_TIMEOUT     (CORR_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_i     (sample_i),
    .sample_q     (sample_q),
    .win_valid    (win_valid),
    .win_i        (win_i),
    .win_q        (win_q),
    .win_last     (win_last),
    .corr_start   (corr_start),
    .corr_done    (corr_done),
    .corr_symbol  (corr_symbol),
    .corr_energy  (corr_energy),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .sync_locked  (sync_locked),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input logic signed [16:0] si, input logic signed [16:0] sq);
    sample_valid = 1'b1;
    sample_i     = si;
    sample_q     = sq;
    tick();
    sample_valid = 1'b0;
  endtask

  // SYNC_COUNT preamble samples then GUARD_LEN discarded samples; ends in COLLECT.
  task automatic acquire();
    for (int k = 0; k < SYNC_COUNT; k++) begin
      drive_sample(17'sd100, 17'($urandom));
      check("hunt_lock", {63'd0, sync_locked}, {63'd0, k == SYNC_COUNT - 1});
    end
    for (int k = 0; k < GUARD_LEN; k++) begin
      drive_sample(17'($urandom), 17'($urandom));
      check("guard_drop", {62'd0, sync_locked, win_valid}, 64'b10);
    end
    m_syms   = 0;
    m_misses = 0;
  endtask

  task automatic send_window(input int count);
    logic signed [16:0] si, sq;
    int gaps;
    for (int k = 0; k < count; k++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        tick();
        check("win_gap", {62'd0, win_valid, corr_start}, 64'b00);
      end
      si = 17'($urandom);
      sq = 17'($urandom);
      drive_sample(si, sq);
      check("win_data", {27'd0, win_valid, win_last, corr_start, win_i, win_q},
            {27'd0, 1'b1, k == N - 1, k == N - 1, si, sq});
    end
  endtask

  // Called in the first EVAL cycle; corr_done arrives after 'delay' cycles.
  task automatic eval_window(input logic [3:0] sym, input logic [31:0] energy,
                             input int delay, input bit with_sample);
    bit accept, frame, locked;
    for (int d = 0; d < delay; d++) begin
      tick();
      check("eval_wait", {62'd0, timeout, sync_locked}, 64'b01);
    end
    corr_done    = 1'b1;
    corr_symbol  = sym;
    corr_energy  = energy;
    sample_valid = with_sample;
    sample_i     = 17'($urandom);
    tick();
    corr_done    = 1'b0;
    sample_valid = 1'b0;
    accept = energy > E_TH;
    frame  = 1'b0;
    if (accept) begin
      m_data   = sym;
      m_syms   = m_syms + 1;
      m_misses = 0;
      frame    = (m_syms == FRAME_SYMBOLS);
    end else begin
      m_misses = m_misses + 1;
    end
    if (with_sample) m_overrun = 1'b1;
    locked = !(frame || (m_misses == MAX_MISSES));
    check("eval_result",
          {55'd0, data_valid, data_out, frame_done, sync_locked, overrun, timeout},
          {55'd0, accept, m_data, frame, locked, m_overrun, 1'b0});
    tick();
    check("eval_pulse_end", {61'd0, data_valid, frame_done, win_valid}, 64'b000);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; corr_done = 1'b0;
    sample_i = '0; sample_q = '0; corr_symbol = '0; corr_energy = '0;
    tick(); tick();
    check("reset_outputs", {18'd0, win_valid, win_i, win_q, win_last, corr_start, data_out,
          data_valid, sync_locked, frame_done, overrun, timeout}, 64'd0);
    reset = 1'b0; enable = 1'b1;
    tick();
    check("hunt_entry", {63'd0, sync_locked}, 64'd0);

    // 7 high, one sample equal to the threshold, then 8 high.
    for (int k = 0; k < 16; k++) begin
      drive_sample((k == 7) ? 17'sd1 : 17'sd100, 17'($urandom));
      check("preamble", {63'd0, sync_locked}, {63'd0, k == 15});
    end
    for (int k = 0; k < GUARD_LEN; k++) begin
      drive_sample(17'($urandom), 17'($urandom));
      check("guard_drop", {62'd0, sync_locked, win_valid}, 64'b10);
    end

    corr_done = 1'b1; corr_symbol = 4'd9; corr_energy = 32'hFFFF_FFFF;
    tick();
    corr_done = 1'b0;
    check("stray_done", {58'd0, data_valid, data_out, sync_locked}, {58'd0, 1'b0, 4'd0, 1'b1});

    // Accept, then two windows at exactly the threshold drop lock.
    send_window(N);
    eval_window(4'd5, 32'd20000, $urandom_range(0, 8), 1'b0);
    send_window(N);
    eval_window(4'($urandom), E_TH, $urandom_range(0, 8), 1'b0);
    send_window(N);
    eval_window(4'($urandom), E_TH, $urandom_range(0, 8), 1'b0);

    // Frame: accept (on the expiry cycle), reject, accept (with overrun), accept.
    acquire();
    send_window(N);
    eval_window(4'($urandom), E_TH + 1, CORR_TIMEOUT - 1, 1'b0);
    send_window(N);
    eval_window(4'($urandom), 32'($urandom_range(0, E_TH)), $urandom_range(0, 8), 1'b0);
    send_window(N);
    eval_window(4'($urandom), E_TH + 1 + $urandom_range(0, 1000000), $urandom_range(0, 8), 1'b1);
    send_window(N);
    eval_window(4'($urandom), E_TH + 1 + $urandom_range(0, 1000000), $urandom_range(0, 8), 1'b0);

    enable = 1'b0;
    tick();
    check("idle_sticky", {61'd0, sync_locked, overrun, timeout}, 64'b010);
    enable = 1'b1;
    tick();
    m_overrun = 1'b0;
    check("idle_exit_clear", {61'd0, sync_locked, overrun, timeout}, 64'b000);

    // Correlator never answers; a sample lands mid-wait.
    acquire();
    send_window(N);
    for (int d = 1; d <= CORR_TIMEOUT; d++) begin
      sample_valid = (d == 4);
      sample_i     = 17'($urandom);
      tick();
      sample_valid = 1'b0;
      if (d == 4) m_overrun = 1'b1;
      check("timeout", {61'd0, timeout, sync_locked, overrun},
            {61'd0, d == CORR_TIMEOUT, d != CORR_TIMEOUT, m_overrun});
    end

    // Reset in the middle of a window.
    enable = 1'b0; tick(); enable = 1'b1; tick();
    acquire();
    send_window(40);
    reset = 1'b1; sample_valid = 1'b1; sample_i = 17'($urandom);
    tick();
    sample_valid = 1'b0;
    check("reset_mid_window", {18'd0, win_valid, win_i, win_q, win_last, corr_start, data_out,
          data_valid, sync_locked, frame_done, overrun, timeout}, 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_sample(17'($urandom), 17'($urandom));
      check("post_reset_quiet", {61'd0, win_valid, corr_start, sync_locked}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
